multicycle_control: RTL and testbench

Main control FSM for the multicycle RV32I-subset datapath. Each instruction runs in 3–5 cycles. The FSM drives the PC register enable, IR load, memory strobes, register-file write and the ALU/result multiplexer selects. It also keeps a retired-instruction counter and a sticky halt on unsupported opcodes. It sits beside the `pc`, `add4`/`addSum` and instruction/data memory blocks and owns all their enables.

---
 rtl/multicycle_control_if.sv | 32 +++
 rtl/multicycle_control.sv | 156 +++++++++++++++
 tb/tb_multicycle_control.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control-side bundle of the multicycle datapath: opcode/zero in, all enables and selects out.
// The master modport is the control FSM; the slave modport is the datapath it steers.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             zero;
    logic             pcWrite;
    logic             adrSrc;
    logic             irWrite;
    logic             memWrite;
    logic             regWrite;
    logic [1:0]       aluSrcA;
    logic [1:0]       aluSrcB;
    logic [1:0]       aluOp;
    logic [1:0]       resultSrc;
    logic [3:0]       state;
    logic [CNT_W-1:0] instrCount;
    logic             halted;

    modport master (
        input  opcode, zero,
        output pcWrite, adrSrc, irWrite, memWrite, regWrite,
               aluSrcA, aluSrcB, aluOp, resultSrc, state, instrCount, halted
    );

    modport slave (
        output opcode, zero,
        input  pcWrite, adrSrc, irWrite, memWrite, regWrite,
               aluSrcA, aluSrcB, aluOp, resultSrc, state, instrCount, halted
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I-subset datapath, with a retired-instruction
// counter and a sticky halt on unsupported opcodes.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        BEQ      = 4'd10,
        HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t           state_q, state_d;
    logic             isStore_q, isStore_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic       pcWrite, adrSrc, irWrite, memWrite, regWrite;
    logic [1:0] aluSrcA, aluSrcB, aluOp, resultSrc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            isStore_q <= 1'b0;
            halted_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            isStore_q <= isStore_d;
            halted_q  <= halted_d;
            count_q   <= count_d;
        end
    end

    // Memory ops remember lw/sw at DECODE so MEMADR need not re-read the IR.
    always_comb begin
        state_d   = FETCH;
        isStore_d = isStore_q;
        halted_d  = halted_q;
        count_d   = count_q;
        pcWrite   = 1'b0;
        adrSrc    = 1'b0;
        irWrite   = 1'b0;
        memWrite  = 1'b0;
        regWrite  = 1'b0;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b00;
        aluOp     = 2'b00;
        resultSrc = 2'b00;
        case (state_q)
            FETCH: begin
                state_d   = DECODE;
                irWrite   = 1'b1;
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                pcWrite   = 1'b1;
            end
            DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
                case (bus.opcode)
                    OP_LW: begin
                        state_d   = MEMADR;
                        isStore_d = 1'b0;
                    end
                    OP_SW: begin
                        state_d   = MEMADR;
                        isStore_d = 1'b1;
                    end
                    OP_R:    state_d = EXECR;
                    OP_I:    state_d = EXECI;
                    OP_BEQ:  state_d = BEQ;
                    default: begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                state_d = isStore_q ? MEMWRITE : MEMREAD;
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
            end
            MEMREAD: begin
                state_d = MEMWB;
                adrSrc  = 1'b1;
            end
            MEMWB: begin
                count_d   = count_q + CNT_W'(1);
                resultSrc = 2'b01;
                regWrite  = 1'b1;
            end
            MEMWRITE: begin
                count_d  = count_q + CNT_W'(1);
                adrSrc   = 1'b1;
                memWrite = 1'b1;
            end
            EXECR: begin
                state_d = ALUWB;
                aluSrcA = 2'b10;
                aluOp   = 2'b10;
            end
            EXECI: begin
                state_d = ALUWB;
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                aluOp   = 2'b10;
            end
            ALUWB: begin
                count_d  = count_q + CNT_W'(1);
                regWrite = 1'b1;
            end
            // Branch is taken by letting the ALU zero flag load the PC from ALUOut.
            BEQ: begin
                count_d = count_q + CNT_W'(1);
                aluSrcA = 2'b10;
                aluOp   = 2'b01;
                pcWrite = bus.zero;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    assign bus.pcWrite    = pcWrite;
    assign bus.adrSrc     = adrSrc;
    assign bus.irWrite    = irWrite;
    assign bus.memWrite   = memWrite;
    assign bus.regWrite   = regWrite;
    assign bus.aluSrcA    = aluSrcA;
    assign bus.aluSrcB    = aluSrcB;
    assign bus.aluOp      = aluOp;
    assign bus.resultSrc  = resultSrc;
    assign bus.state      = state_q;
    assign bus.instrCount = count_q;
    assign bus.halted     = halted_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a per-opcode state-sequence model checked every
// cycle, plus directed instruction runs with hand-computed traces.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'b0000000;
    logic       zero = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(32)) bus ();
    multicycle_control_if #(.CNT_W(4))  busW ();

    assign bus.opcode  = opcode;
    assign bus.zero    = zero;
    assign busW.opcode = opcode;
    assign busW.zero   = zero;

    multicycle_control #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    multicycle_control #(.CNT_W(4))  dutW (.clk(clk), .reset(reset), .bus(busW));

    // {pcWrite, adrSrc, irWrite, memWrite, regWrite, aluSrcA, aluSrcB, aluOp, resultSrc}
    logic [12:0] dutOut;
    assign dutOut = {bus.pcWrite, bus.adrSrc, bus.irWrite, bus.memWrite, bus.regWrite,
                     bus.aluSrcA, bus.aluSrcB, bus.aluOp, bus.resultSrc};

    localparam logic [12:0] FETCH_OUT = 13'b1_0_1_0_0_00_10_00_10;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [12:0] expOut(input int s, input logic z);
        case (s)
            0:       return FETCH_OUT;
            1:       return 13'b0_0_0_0_0_01_01_00_00;
            2:       return 13'b0_0_0_0_0_10_01_00_00;
            3:       return 13'b0_1_0_0_0_00_00_00_00;
            4:       return 13'b0_0_0_0_1_00_00_00_01;
            5:       return 13'b0_1_0_1_0_00_00_00_00;
            6:       return 13'b0_0_0_0_0_10_00_10_00;
            7:       return 13'b0_0_0_0_1_00_00_00_00;
            8:       return 13'b0_0_0_0_0_10_01_10_00;
            10:      return {z, 12'b0_0_0_0_10_00_01_00};
            default: return 13'b0;
        endcase
    endfunction

    // Model: each opcode expands into the list of states it visits after DECODE.
    int   mState = 0;
    int   mCount = 0;
    logic mHalt = 1'b0;
    int   pending[$];

    task automatic loadSeq(input int a, input int b, input int c);
        pending.delete();
        if (a != 0) pending.push_back(a);
        if (b != 0) pending.push_back(b);
        if (c != 0) pending.push_back(c);
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mState = 0;
            mCount = 0;
            mHalt  = 1'b0;
            pending.delete();
        end else if (mState == 11) begin
            mState = 11;
        end else if (mState == 0) begin
            mState = 1;
        end else if (mState == 1) begin
            case (opcode)
                7'b0000011: loadSeq(2, 3, 4);
                7'b0100011: loadSeq(2, 5, 0);
                7'b0110011: loadSeq(6, 7, 0);
                7'b0010011: loadSeq(8, 7, 0);
                7'b1100011: loadSeq(10, 0, 0);
                default: begin
                    loadSeq(11, 0, 0);
                    mHalt = 1'b1;
                end
            endcase
            mState = pending.pop_front();
        end else if (pending.size() > 0) begin
            mState = pending.pop_front();
        end else begin
            mCount++;
            mState = 0;
        end
    end

    always @(negedge clk) begin
        checkOutput("outputs", 32'(dutOut), 32'(expOut(mState, zero)));
        checkOutput("state", 32'(bus.state), 32'(mState));
        checkOutput("stateW", 32'(busW.state), 32'(mState));
        checkOutput("instrCount", bus.instrCount, 32'(mCount));
        checkOutput("instrCountW", 32'(busW.instrCount), 32'(mCount % 16));
        checkOutput("halted", 32'(bus.halted), 32'(mHalt));
    end

    logic [31:0] stTr, rwTr, mwTr, pcTr, adTr, rsTr;

    // Called just after a rising edge with the DUT in FETCH; returns just after the edge
    // that ends the requested number of cycles.
    task automatic applyStimulus(input logic [6:0] op, input logic z, input int cycles);
        opcode = op;
        zero   = z;
        stTr = '0; rwTr = '0; mwTr = '0; pcTr = '0; adTr = '0; rsTr = '0;
        repeat (cycles) begin
            @(negedge clk);
            stTr = (stTr << 4) | 32'(bus.state);
            rwTr = (rwTr << 1) | 32'(bus.regWrite);
            mwTr = (mwTr << 1) | 32'(bus.memWrite);
            pcTr = (pcTr << 1) | 32'(bus.pcWrite);
            adTr = (adTr << 1) | 32'(bus.adrSrc);
            rsTr = (rsTr << 2) | 32'(bus.resultSrc);
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #1;
        checkOutput("rstState", 32'(bus.state), 32'd0);
        checkOutput("rstOutputs", 32'(dutOut), 32'(FETCH_OUT));
        checkOutput("rstCount", bus.instrCount, 32'd0);
        checkOutput("rstHalted", 32'(bus.halted), 32'd0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b0;

        applyStimulus(7'b0110011, 1'b0, 4);
        checkOutput("rTypeStates", stTr, 32'h0167);
        checkOutput("rTypeRegWrite", rwTr, 32'b0001);
        checkOutput("rTypeCount", bus.instrCount, 32'd1);

        applyStimulus(7'b0000011, 1'b0, 5);
        checkOutput("lwStates", stTr, 32'h01234);
        checkOutput("lwAdrSrc", adTr, 32'b00010);
        checkOutput("lwRegWrite", rwTr, 32'b00001);
        checkOutput("lwResultSrc", rsTr, 32'b10_00_00_00_01);
        checkOutput("lwCount", bus.instrCount, 32'd2);

        applyStimulus(7'b0100011, 1'b0, 4);
        checkOutput("swStates", stTr, 32'h0125);
        checkOutput("swMemWrite", mwTr, 32'b0001);
        checkOutput("swRegWrite", rwTr, 32'b0000);
        checkOutput("swCount", bus.instrCount, 32'd3);

        applyStimulus(7'b1100011, 1'b1, 3);
        checkOutput("beqStates", stTr, 32'h01A);
        checkOutput("beqTakenPc", pcTr, 32'b101);
        applyStimulus(7'b1100011, 1'b0, 3);
        checkOutput("beqNotTakenPc", pcTr, 32'b100);
        checkOutput("beqCount", bus.instrCount, 32'd5);

        // pcWrite in BEQ must follow zero without waiting for an edge.
        applyStimulus(7'b1100011, 1'b0, 2);
        checkOutput("beqCombState", 32'(bus.state), 32'd10);
        checkOutput("beqCombLow", 32'(bus.pcWrite), 32'd0);
        zero = 1'b1;
        #1;
        checkOutput("beqCombHigh", 32'(bus.pcWrite), 32'd1);
        @(posedge clk); #2;
        zero = 1'b0;
        checkOutput("beqCombCount", bus.instrCount, 32'd6);

        applyStimulus(7'b1101111, 1'b0, 2);
        checkOutput("haltEntry", stTr, 32'h01);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("haltState", 32'(bus.state), 32'd11);
            checkOutput("haltStrobes", 32'(dutOut), 32'd0);
        end
        checkOutput("haltFlag", 32'(bus.halted), 32'd1);
        checkOutput("haltCount", bus.instrCount, 32'd6);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("haltRstState", 32'(bus.state), 32'd0);
        checkOutput("haltRstFlag", 32'(bus.halted), 32'd0);
        checkOutput("haltRstCount", bus.instrCount, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;

        applyStimulus(7'b0010011, 1'b0, 4);
        checkOutput("iTypeStates", stTr, 32'h0187);
        for (int i = 1; i < 15; i++) applyStimulus(7'b0010011, 1'b0, 4);
        checkOutput("wrap15", 32'(busW.instrCount), 32'd15);
        applyStimulus(7'b0010011, 1'b0, 4);
        checkOutput("wrapTo0", 32'(busW.instrCount), 32'd0);
        checkOutput("wideCount16", bus.instrCount, 32'd16);

        opcode = 7'b0000011;
        repeat (3) begin
            @(posedge clk); #2;
        end
        checkOutput("midLwState", 32'(bus.state), 32'd3);
        reset = 1'b1;
        #1;
        checkOutput("midRstState", 32'(bus.state), 32'd0);
        checkOutput("midRstCount", bus.instrCount, 32'd0);
        @(negedge clk);
        checkOutput("midRstRegWrite", 32'(bus.regWrite), 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        applyStimulus(7'b0110011, 1'b0, 4);
        checkOutput("postRstRegWrite", rwTr, 32'b0001);
        checkOutput("postRstCount", bus.instrCount, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
